// File: rtl/prog_nibble_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_nibble_responder: flop-based 12-bit program store serving nibbles to  |
// | a nibble-fetch CPU, with load port and bus protocol monitor. Rev 1.0       |
// +----------------------------------------------------------------------------+
module prog_nibble_responder #(
  parameter int           DEPTH = 16,
  parameter int           AW    = 6,
  parameter logic [11:0]  FILL  = 12'h000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    i_cpu_addr,
  input  logic          i_cpu_ph2,
  input  logic          i_cpu_ph3,
  output logic [3:0]    o_nib_out,
  input  logic          i_run,
  input  logic          i_ld_valid,
  output logic          o_ld_ready,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [11:0]   i_ld_data,
  output logic [7:0]    o_ld_count,
  output logic [15:0]   o_instr_count,
  output logic          o_err,
  output logic [1:0]    o_err_code,
  input  logic          i_err_clr
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [9:0]  c_DEPTH_CPU = 10'(DEPTH);
  localparam logic [AW:0] c_DEPTH_LD  = (AW+1)'(DEPTH);

  // Phase encoding is simply {ph3, ph2}
  localparam logic [1:0] c_PH_P1  = 2'b00;
  localparam logic [1:0] c_PH_P2  = 2'b01;
  localparam logic [1:0] c_PH_P3  = 2'b10;
  localparam logic [1:0] c_PH_ILL = 2'b11;

  localparam logic [1:0] c_ERR_PHASE = 2'b01;
  localparam logic [1:0] c_ERR_ORDER = 2'b10;
  localparam logic [1:0] c_ERR_ADDR  = 2'b11;

  logic [11:0] r_mem [DEPTH];
  logic [7:0]  r_ld_count;
  logic [15:0] r_instr_count;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic        r_armed;
  logic [1:0]  r_prev_phase;
  logic [9:0]  r_prev_addr;

  logic [1:0]  w_phase;
  logic [11:0] w_word;
  logic        w_ld_fire;
  logic        w_ld_in_range;
  logic [1:0]  w_exp_phase;
  logic        w_err_hit;
  logic [1:0]  w_err_code;

  assign w_phase       = {i_cpu_ph3, i_cpu_ph2};
  assign w_word        = (i_cpu_addr < c_DEPTH_CPU) ? r_mem[i_cpu_addr[IW-1:0]] : FILL;
  assign o_ld_ready    = !i_run;
  assign w_ld_fire     = i_ld_valid && o_ld_ready;
  assign w_ld_in_range = {1'b0, i_ld_addr} < c_DEPTH_LD;

  always_comb begin
    o_nib_out = 4'h0;
    if (i_run) begin
      case (w_phase)
        c_PH_P1: o_nib_out = w_word[3:0];
        c_PH_P2: o_nib_out = w_word[7:4];
        c_PH_P3: o_nib_out = w_word[11:8];
        default: o_nib_out = 4'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= FILL;
    end else if (w_ld_fire && w_ld_in_range) begin
      r_mem[i_ld_addr[IW-1:0]] <= i_ld_data;
    end
  end

  always_comb begin
    case (r_prev_phase)
      c_PH_P1: w_exp_phase = c_PH_P2;
      c_PH_P2: w_exp_phase = c_PH_P3;
      default: w_exp_phase = c_PH_P1;
    endcase
  end

  // Checks are listed in priority order; only the first failing one reports
  always_comb begin
    w_err_hit  = 1'b0;
    w_err_code = 2'b00;
    if (i_run && r_armed) begin
      if (w_phase == c_PH_ILL) begin
        w_err_hit  = 1'b1;
        w_err_code = c_ERR_PHASE;
      end else if (w_phase != w_exp_phase) begin
        w_err_hit  = 1'b1;
        w_err_code = c_ERR_ORDER;
      end else if ((r_prev_phase == c_PH_P3) ? (i_cpu_addr != r_prev_addr + 10'd1)
                                              : (i_cpu_addr != r_prev_addr)) begin
        w_err_hit  = 1'b1;
        w_err_code = c_ERR_ADDR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed      <= 1'b0;
      r_prev_phase <= c_PH_P3;
      r_prev_addr  <= 10'd0;
    end else if (i_run) begin
      r_armed     <= 1'b1;
      r_prev_addr <= i_cpu_addr;
      if (w_phase != c_PH_ILL) r_prev_phase <= w_phase;
    end else begin
      r_armed <= 1'b0;
    end
  end

  // A new error in the clear cycle wins over the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else if (w_err_hit && (!r_err || i_err_clr)) begin
      r_err      <= 1'b1;
      r_err_code <= w_err_code;
    end else if (i_err_clr) begin
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_count    <= 8'd0;
      r_instr_count <= 16'd0;
    end else begin
      if (w_ld_fire && (r_ld_count != 8'hFF)) r_ld_count <= r_ld_count + 8'd1;
      if (i_run && (w_phase == c_PH_P3))      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign o_ld_count    = r_ld_count;
  assign o_instr_count = r_instr_count;
  assign o_err         = r_err;
  assign o_err_code    = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_prog_nibble_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prog_nibble_responder: directed self-checking bench. Rev 1.0            |
// +----------------------------------------------------------------------------+
module tb_prog_nibble_responder;

  logic        clk;
  logic        rst_n;
  logic [9:0]  r_cpu_addr;
  logic        r_ph2, r_ph3;
  logic [3:0]  w_nib_out;
  logic        r_run;
  logic        r_ld_valid;
  logic        w_ld_ready;
  logic [5:0]  r_ld_addr;
  logic [11:0] r_ld_data;
  logic [7:0]  w_ld_count;
  logic [15:0] w_instr_count;
  logic        w_err;
  logic [1:0]  w_err_code;
  logic        r_err_clr;

  int n_total = 0;
  int n_bad   = 0;

  prog_nibble_responder #(.DEPTH(16), .AW(6), .FILL(12'h000)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cpu_addr    (r_cpu_addr),
    .i_cpu_ph2     (r_ph2),
    .i_cpu_ph3     (r_ph3),
    .o_nib_out     (w_nib_out),
    .i_run         (r_run),
    .i_ld_valid    (r_ld_valid),
    .o_ld_ready    (w_ld_ready),
    .i_ld_addr     (r_ld_addr),
    .i_ld_data     (r_ld_data),
    .o_ld_count    (w_ld_count),
    .o_instr_count (w_instr_count),
    .o_err         (w_err),
    .o_err_code    (w_err_code),
    .i_err_clr     (r_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ph: 1=P1 2=P2 3=P3 0=illegal; settles combinational outputs before returning
  task automatic bus(input logic [9:0] addr, input int ph);
    r_cpu_addr = addr;
    r_ph2 = (ph == 2) || (ph == 0);
    r_ph3 = (ph == 3) || (ph == 0);
    #1;
  endtask

  task automatic load(input logic [5:0] a, input logic [11:0] d);
    r_ld_valid = 1'b1;
    r_ld_addr  = a;
    r_ld_data  = d;
    tick();
    r_ld_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; r_run = 1'b0; r_ld_valid = 1'b0; r_ld_addr = '0; r_ld_data = '0;
    r_err_clr = 1'b0; r_cpu_addr = '0; r_ph2 = 1'b0; r_ph3 = 1'b0;
    #3;
    chk("rst_err", w_err, 0);
    chk("rst_code", w_err_code, 0);
    chk("rst_ldcnt", w_ld_count, 0);
    chk("rst_icnt", w_instr_count, 0);
    chk("rst_ready", w_ld_ready, 1);
    tick(); tick();
    rst_n = 1'b1;

    // FILL contents served after reset
    r_run = 1'b1;
    bus(10'd0, 1); chk("fill_p1", w_nib_out, 0); tick();
    bus(10'd0, 2); chk("fill_p2", w_nib_out, 0); tick();
    bus(10'd0, 3); chk("fill_p3", w_nib_out, 0); tick();
    chk("fill_icnt", w_instr_count, 1);
    chk("fill_err", w_err, 0);

    // Load three words, the last one out of range
    r_run = 1'b0;
    bus(10'd0, 1);
    chk("ld_ready_idle", w_ld_ready, 1);
    r_ld_valid = 1'b1; r_ld_addr = 6'd0;  r_ld_data = 12'hA53; tick();
    r_ld_addr = 6'd1;  r_ld_data = 12'h7C4; tick();
    r_ld_addr = 6'd20; r_ld_data = 12'hFFF; tick();
    r_ld_valid = 1'b0;
    chk("ld_count3", w_ld_count, 3);
    chk("nib_load_mode", w_nib_out, 0);

    // Run rises with ld_valid still high: no transfer, mem[0] intact
    r_ld_valid = 1'b1; r_ld_addr = 6'd0; r_ld_data = 12'h000;
    r_run = 1'b1;
    bus(10'd0, 1); chk("ready_run", w_ld_ready, 0); chk("w0_p1", w_nib_out, 4'h3); tick();
    bus(10'd0, 2); chk("w0_p2", w_nib_out, 4'h5); tick();
    bus(10'd0, 3); chk("w0_p3", w_nib_out, 4'hA); tick();
    bus(10'd1, 1); chk("w1_p1", w_nib_out, 4'h4); tick();
    bus(10'd1, 2); chk("w1_p2", w_nib_out, 4'hC); tick();
    bus(10'd1, 3); chk("w1_p3", w_nib_out, 4'h7); tick();
    r_ld_valid = 1'b0;
    chk("ld_count_hold", w_ld_count, 3);
    chk("run_err0", w_err, 0);

    // Re-enter run at addr 20 so the jump is not a step error
    r_run = 1'b0; tick();
    r_run = 1'b1;
    bus(10'd20, 1); chk("w20_p1", w_nib_out, 0); tick();
    bus(10'd20, 2); chk("w20_p2", w_nib_out, 0); tick();
    bus(10'd20, 3); chk("w20_p3", w_nib_out, 0); tick();
    chk("w20_err0", w_err, 0);
    chk("icnt4", w_instr_count, 4);

    // Reset, then a long legal stream crossing the 1023 -> 0 wrap
    rst_n = 1'b0; #1; rst_n = 1'b1;
    chk("mem_lost", w_nib_out, 0);
    for (int a = 0; a < 1026; a++) begin
      bus(10'(a % 1024), 1); tick();
      bus(10'(a % 1024), 2); tick();
      bus(10'(a % 1024), 3); tick();
    end
    chk("stream_err", w_err, 0);
    chk("stream_icnt", w_instr_count, 1026);

    // P1 followed by P3 -> phase order error
    bus(10'd2, 1); tick();
    chk("pre_order_err", w_err, 0);
    bus(10'd2, 3); tick();
    chk("order_err", w_err, 1);
    chk("order_code", w_err_code, 2'b10);
    bus(10'd2, 0); chk("ill_nib", w_nib_out, 0); tick();
    chk("order_code_kept", w_err_code, 2'b10);

    // Clear while out of run
    r_run = 1'b0; r_err_clr = 1'b1; tick();
    r_err_clr = 1'b0;
    chk("clr_err", w_err, 0);
    chk("clr_code", w_err_code, 0);

    // P3 at 5 then P1 at 7 -> address step error
    r_run = 1'b1;
    bus(10'd5, 3); tick();
    chk("arm_no_err", w_err, 0);
    bus(10'd7, 1); tick();
    chk("step_err", w_err, 1);
    chk("step_code", w_err_code, 2'b11);
    r_err_clr = 1'b1; bus(10'd7, 0); tick();
    r_err_clr = 1'b0;
    chk("clr_new_err", w_err, 1);
    chk("clr_new_code", w_err_code, 2'b01);

    // Asynchronous reset in the middle of P2
    bus(10'd8, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_err", w_err, 0);
    chk("arst_code", w_err_code, 0);
    chk("arst_icnt", w_instr_count, 0);
    chk("arst_ldcnt", w_ld_count, 0);
    tick();
    rst_n = 1'b1;
    bus(10'd9, 3); tick();
    chk("post_rst_err", w_err, 0);
    chk("post_rst_icnt", w_instr_count, 1);
    bus(10'd10, 1); tick();
    chk("post_rst_err2", w_err, 0);

    // Load counter saturation, writes out of range
    r_run = 1'b0;
    for (int i = 0; i < 260; i++) load(6'd63, 12'h123);
    chk("ld_sat", w_ld_count, 255);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
